mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter CALC_CYC, default 7, cycles spent in CALC per tile (min 1).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port START  input  1  job request pulse, sampled only in IDLE.
REQ-005 SHALL have port NTILE  input  4  tiles in job, sampled with START.
REQ-006 SHALL have port REUSE_W  input  1  load weights on first tile only, sampled with START.
REQ-007 SHALL have port SHAMT_CFG  input  5  output shift amount, sampled with START.
REQ-008 SHALL have port ODST_BASE  input  4  first output destination index, sampled with START.
REQ-009 SHALL have port MEM_VALID  input  1  operand memory has a valid row/column this cycle.
REQ-010 SHALL have ports START_CALC0 1, ILoad0 1, WLoad0 1, shamt0 5, ICOL0 2, WROW0 2, ODST0 4, all outputs, driving the MAC pipeline-register inputs of the same names.
REQ-011 SHALL have port BUSY  output  1  high in any state except IDLE.
REQ-012 SHALL have port DONE  output  1  one-cycle job-complete pulse.

Function
REQ-013 SHALL implement states IDLE, LOADW, LOADI, CALC, FIN.
REQ-014 IDLE: on START=1 with NTILE!=0, SHALL latch NTILE/REUSE_W/SHAMT_CFG/ODST_BASE, clear tile index, go to LOADW next cycle.
REQ-015 IDLE: on START=1 with NTILE=0, SHALL go to FIN with no load or calc activity.
REQ-016 LOADW: WLoad0 SHALL equal MEM_VALID; WROW0 SHALL show row counter; counter increments only when MEM_VALID=1.
REQ-017 LOADW: on MEM_VALID=1 with row counter 3, SHALL wrap counter to 0 and go to LOADI.
REQ-018 LOADI: ILoad0 SHALL equal MEM_VALID; ICOL0 SHALL show column counter; same advance/wrap rule, exit to CALC.
REQ-019 MEM_VALID=0 during LOADW/LOADI SHALL stall the counter with WLoad0/ILoad0 low; no timeout.
REQ-020 CALC: START_CALC0 SHALL be 1 only in the first CALC cycle; state SHALL last exactly CALC_CYC cycles.
REQ-021 shamt0 SHALL equal latched shift amount in every non-IDLE state; ODST0 SHALL equal (latched base + tile index) mod 16 in every non-IDLE state.
REQ-022 CALC end: if tile index+1 < latched NTILE, SHALL increment tile index and go to LOADI when REUSE_W=1, else LOADW; otherwise go to FIN.
REQ-023 FIN: DONE=1 for one cycle, then IDLE; next START accepted in the IDLE cycle after FIN.
REQ-024 START outside IDLE SHALL be ignored; input changes outside START sampling SHALL not affect a running job.
REQ-025 WLoad0 and ILoad0 SHALL never be high in the same cycle; START_CALC0 SHALL never coincide with either.
REQ-026 Outputs SHALL be decoded from registered state and counters; only WLoad0/ILoad0 may depend combinationally on MEM_VALID.
REQ-027 In IDLE, all control outputs SHALL be 0.

Reset
REQ-028 RSTN low SHALL immediately force IDLE, clear counters, tile index and latched config; every output reads 0.
REQ-029 Reset mid-job SHALL abandon the job with no DONE pulse; first START after release SHALL be honoured normally.

Structure
REQ-030 State encoding, array dimension 4 and index widths SHALL live in the shared MAC package with the MAC-array constants.
REQ-031 Calc-cycle counter SHALL be one sub-module, mac_cycle_cnt (load, enable, terminal-count flag); the rest is flat.

Verification
REQ-032 NTILE=1, REUSE_W=0, MEM_VALID=1: WLoad0 cycles 1-4 with WROW0 0..3, ILoad0 cycles 5-8 with ICOL0 0..3, START_CALC0 cycle 9, DONE cycle 16.
REQ-033 NTILE=3, REUSE_W=1, ODST_BASE=14: LOADW once; ODST0 14, 15, 0 per tile; exactly 3 START_CALC0 pulses, one DONE.
REQ-034 MEM_VALID low 2 cycles at WROW0=2: WROW0 holds 2 with WLoad0=0, job finishes 2 cycles late, 4 WLoad0 pulses total.
REQ-035 START with NTILE=0: FIN next cycle, DONE one cycle, no WLoad0/ILoad0/START_CALC0.
REQ-036 RSTN low during CALC of tile 2: all outputs 0 immediately, no DONE; new START after release runs from tile 0.
REQ-037 START pulsed while BUSY, with changed SHAMT_CFG: ignored, shamt0 keeps job value throughout.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared MAC-array constants and sequencer state encoding.
package mac_seq_ctrl_pkg;

  // MAC array geometry and datapath widths
  localparam int unsigned MacDim  = 4;
  localparam int unsigned IdxW    = 2;
  localparam int unsigned DataW   = 8;
  localparam int unsigned AccW    = 2 * DataW + IdxW;

  // Sequencer field widths
  localparam int unsigned TileW   = 4;
  localparam int unsigned ShamtW  = 5;
  localparam int unsigned OdstW   = 4;

  localparam logic [IdxW-1:0] IdxMax = IdxW'(MacDim - 1);

  // Sequencer states (plain constants for compatibility with older blocks)
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadW = 3'd1;
  localparam logic [2:0] StLoadI = 3'd2;
  localparam logic [2:0] StCalc  = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  // Row/column index advance; wraps naturally at MacDim
  function automatic logic [IdxW-1:0] idx_next(input logic [IdxW-1:0] idx);
    return idx + IdxW'(1);
  endfunction

endpackage

// File: rtl/mac_cycle_cnt.sv
// Down-counter for the CALC phase: load a start value, count down while enabled,
// flag terminal count at zero.
module mac_cycle_cnt #(
  parameter int unsigned Width = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             tc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc  = (cnt_q == '0);
  assign cnt = cnt_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Tile sequencer for the MAC array: loads weights (optionally once per job),
// loads inputs, runs CALC for CALC_CYC cycles per tile, then pulses DONE.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned CALC_CYC = 7
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [TileW-1:0]  NTILE,
  input  logic              REUSE_W,
  input  logic [ShamtW-1:0] SHAMT_CFG,
  input  logic [OdstW-1:0]  ODST_BASE,
  input  logic              MEM_VALID,
  output logic              START_CALC0,
  output logic              ILoad0,
  output logic              WLoad0,
  output logic [ShamtW-1:0] shamt0,
  output logic [IdxW-1:0]   ICOL0,
  output logic [IdxW-1:0]   WROW0,
  output logic [OdstW-1:0]  ODST0,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned   CntW    = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(CALC_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [IdxW-1:0]   row_q, row_d;
  logic [IdxW-1:0]   col_q, col_d;
  logic [TileW-1:0]  tile_q, tile_d;
  logic [TileW-1:0]  ntile_q, ntile_d;
  logic              reuse_q, reuse_d;
  logic [ShamtW-1:0] shamt_q, shamt_d;
  logic [OdstW-1:0]  base_q, base_d;

  logic              cnt_load, cnt_en, cnt_tc;
  logic [CntW-1:0]   cnt;

  mac_cycle_cnt #(
    .Width (CntW)
  ) u_cycle_cnt (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .load     (cnt_load),
    .load_val (CntLoad),
    .en       (cnt_en),
    .tc       (cnt_tc),
    .cnt      (cnt)
  );

  // Next-state, counter advance and job-config capture
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    tile_d   = tile_q;
    ntile_d  = ntile_q;
    reuse_d  = reuse_q;
    shamt_d  = shamt_q;
    base_d   = base_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          if (NTILE != '0) begin
            ntile_d = NTILE;
            reuse_d = REUSE_W;
            shamt_d = SHAMT_CFG;
            base_d  = ODST_BASE;
            tile_d  = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = StLoadW;
          end else begin
            // Empty job: report completion without touching the array
            state_d = StFin;
          end
        end
      end
      StLoadW: begin
        if (MEM_VALID) begin
          row_d = idx_next(row_q);
          if (row_q == IdxMax) begin
            state_d = StLoadI;
          end
        end
      end
      StLoadI: begin
        if (MEM_VALID) begin
          col_d = idx_next(col_q);
          if (col_q == IdxMax) begin
            state_d  = StCalc;
            cnt_load = 1'b1;
          end
        end
      end
      StCalc: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (({1'b0, tile_q} + 5'd1) < {1'b0, ntile_q}) begin
            tile_d  = tile_q + TileW'(1);
            state_d = reuse_q ? StLoadI : StLoadW;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and latched job configuration
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      tile_q  <= '0;
      ntile_q <= '0;
      reuse_q <= 1'b0;
      shamt_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      ntile_q <= ntile_d;
      reuse_q <= reuse_d;
      shamt_q <= shamt_d;
      base_q  <= base_d;
    end
  end

  // Output decode; only the load strobes look at MEM_VALID directly
  always_comb begin
    BUSY        = (state_q != StIdle);
    DONE        = (state_q == StFin);
    WLoad0      = (state_q == StLoadW) && MEM_VALID;
    ILoad0      = (state_q == StLoadI) && MEM_VALID;
    WROW0       = (state_q == StLoadW) ? row_q : '0;
    ICOL0       = (state_q == StLoadI) ? col_q : '0;
    START_CALC0 = (state_q == StCalc) && (cnt == CntLoad);
    shamt0      = BUSY ? shamt_q : '0;
    ODST0       = BUSY ? (base_q + tile_q) : '0;
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomised and directed bench for mac_seq_ctrl against a step-list reference model.
module tb_mac_seq_ctrl;

  localparam int unsigned CalcCyc = 7;

  localparam int KNone = 0;
  localparam int KW    = 1;
  localparam int KI    = 2;
  localparam int KCf   = 3;
  localparam int KC    = 4;
  localparam int KFin  = 5;

  logic       CLK, RSTN, START, REUSE_W, MEM_VALID;
  logic [3:0] NTILE, ODST_BASE;
  logic [4:0] SHAMT_CFG;
  logic       START_CALC0, ILoad0, WLoad0, BUSY, DONE;
  logic [4:0] shamt0;
  logic [1:0] ICOL0, WROW0;
  logic [3:0] ODST0;

  mac_seq_ctrl #(
    .CALC_CYC (CalcCyc)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .START       (START),
    .NTILE       (NTILE),
    .REUSE_W     (REUSE_W),
    .SHAMT_CFG   (SHAMT_CFG),
    .ODST_BASE   (ODST_BASE),
    .MEM_VALID   (MEM_VALID),
    .START_CALC0 (START_CALC0),
    .ILoad0      (ILoad0),
    .WLoad0      (WLoad0),
    .shamt0      (shamt0),
    .ICOL0       (ICOL0),
    .WROW0       (WROW0),
    .ODST0       (ODST0),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the remaining job as a list of per-cycle steps
  typedef struct {
    int         kind;
    int         idx;
    logic [3:0] odst;
    logic [4:0] sh;
  } step_t;

  step_t      q[$];
  logic [3:0] lat_base, lat_tile;
  logic [4:0] lat_shamt;

  int n_checks, n_fail;
  int cyc_n, first_calc_at, done_at, n_wl, n_il, n_sc, n_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_step(input int kind, input int idx, input logic [3:0] od,
                           input logic [4:0] sh);
    step_t s;
    s.kind = kind;
    s.idx  = idx;
    s.odst = od;
    s.sh   = sh;
    q.push_back(s);
  endtask

  // Expand an accepted START into the full step list of the job
  task automatic build_job(input logic [3:0] nt, input logic rw, input logic [4:0] sh,
                           input logic [3:0] ob);
    logic [3:0] od;
    if (nt == 0) begin
      push_step(KFin, 0, lat_base + lat_tile, lat_shamt);
    end else begin
      for (int t = 0; t < int'(nt); t++) begin
        od = 4'((int'(ob) + t) % 16);
        if (t == 0 || !rw) for (int i = 0; i < 4; i++) push_step(KW, i, od, sh);
        for (int i = 0; i < 4; i++) push_step(KI, i, od, sh);
        push_step(KCf, 0, od, sh);
        for (int c = 1; c < int'(CalcCyc); c++) push_step(KC, 0, od, sh);
      end
      od = 4'((int'(ob) + int'(nt) - 1) % 16);
      push_step(KFin, 0, od, sh);
      lat_base  = ob;
      lat_shamt = sh;
      lat_tile  = nt - 4'd1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    lat_base  = '0;
    lat_tile  = '0;
    lat_shamt = '0;
  endtask

  task automatic clear_counts();
    cyc_n = 0; first_calc_at = -1; done_at = -1;
    n_wl = 0; n_il = 0; n_sc = 0; n_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wl"}, 32'(WLoad0), 0);
    check_eq({tag, "_il"}, 32'(ILoad0), 0);
    check_eq({tag, "_sc"}, 32'(START_CALC0), 0);
    check_eq({tag, "_busy"}, 32'(BUSY), 0);
    check_eq({tag, "_done"}, 32'(DONE), 0);
    check_eq({tag, "_shamt"}, 32'(shamt0), 0);
    check_eq({tag, "_odst"}, 32'(ODST0), 0);
    check_eq({tag, "_wrow"}, 32'(WROW0), 0);
    check_eq({tag, "_icol"}, 32'(ICOL0), 0);
  endtask

  // One clock cycle: drive, compare against the model at the falling edge, advance model
  task automatic cycle(input logic st, input logic [3:0] nt, input logic rw,
                       input logic [4:0] sh, input logic [3:0] ob, input logic mv);
    int  kind, idx;
    logic [4:0] e_sh;
    logic [3:0] e_od;
    @(posedge CLK);
    #1;
    START = st; NTILE = nt; REUSE_W = rw; SHAMT_CFG = sh; ODST_BASE = ob; MEM_VALID = mv;
    kind = (q.size() != 0) ? q[0].kind : KNone;
    idx  = (q.size() != 0) ? q[0].idx : 0;
    e_sh = (q.size() != 0) ? q[0].sh : 5'd0;
    e_od = (q.size() != 0) ? q[0].odst : 4'd0;
    @(negedge CLK);
    check_eq("wload",  32'(WLoad0), 32'(kind == KW && mv));
    check_eq("iload",  32'(ILoad0), 32'(kind == KI && mv));
    check_eq("wrow",   32'(WROW0), (kind == KW) ? 32'(idx) : 0);
    check_eq("icol",   32'(ICOL0), (kind == KI) ? 32'(idx) : 0);
    check_eq("scalc",  32'(START_CALC0), 32'(kind == KCf));
    check_eq("busy",   32'(BUSY), 32'(kind != KNone));
    check_eq("done",   32'(DONE), 32'(kind == KFin));
    check_eq("shamt",  32'(shamt0), 32'(e_sh));
    check_eq("odst",   32'(ODST0), 32'(e_od));
    if (START_CALC0 && first_calc_at < 0) first_calc_at = cyc_n;
    if (DONE) done_at = cyc_n;
    n_wl   += int'(WLoad0);
    n_il   += int'(ILoad0);
    n_sc   += int'(START_CALC0);
    n_done += int'(DONE);
    cyc_n++;
    if (kind == KNone) begin
      if (st) build_job(nt, rw, sh, ob);
    end else if (!((kind == KW || kind == KI) && !mv)) begin
      void'(q.pop_front());
    end
  endtask

  // Run a whole job. mode 0: memory always valid, 1: random valid,
  // 2: two stall cycles when weight row 2 is due. Spurious STARTs are thrown in.
  task automatic run_job(input logic [3:0] nt, input logic rw, input logic [4:0] sh,
                         input logic [3:0] ob, input int mode);
    int   k, stall;
    logic mv;
    clear_counts();
    stall = 2;
    cycle(1'b1, nt, rw, sh, ob, 1'b1);
    k = 0;
    while (q.size() != 0 && k < 2000) begin
      mv = 1'b1;
      if (mode == 1) mv = ($urandom_range(0, 3) != 0);
      if (mode == 2 && q[0].kind == KW && q[0].idx == 2 && stall > 0) begin
        mv = 1'b0;
        stall--;
      end
      cycle((k % 3) == 0, 4'($urandom), 1'($urandom), ~sh, 4'($urandom), mv);
      k++;
    end
    if (k >= 2000) check_eq("job_timeout", 1, 0);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    clear_counts();
    RSTN = 1'b0; START = 1'b0; NTILE = '0; REUSE_W = 1'b0;
    SHAMT_CFG = '0; ODST_BASE = '0; MEM_VALID = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RSTN = 1'b1;

    // Single tile, no stalls: exact cycle positions
    run_job(4'd1, 1'b0, 5'd3, 4'd5, 0);
    check_eq("t1_first_calc", 32'(first_calc_at), 9);
    check_eq("t1_done_at", 32'(done_at), 16);
    check_eq("t1_wl", 32'(n_wl), 4);
    check_eq("t1_il", 32'(n_il), 4);

    // Three tiles with weight reuse and ODST wrap
    run_job(4'd3, 1'b1, 5'd17, 4'd14, 0);
    check_eq("t3_sc", 32'(n_sc), 3);
    check_eq("t3_done", 32'(n_done), 1);
    check_eq("t3_wl", 32'(n_wl), 4);
    check_eq("t3_il", 32'(n_il), 12);

    // Two-cycle stall on weight row 2
    run_job(4'd1, 1'b0, 5'd9, 4'd2, 2);
    check_eq("stall_done_at", 32'(done_at), 18);
    check_eq("stall_wl", 32'(n_wl), 4);

    // Empty job
    run_job(4'd0, 1'b0, 5'd31, 4'd7, 0);
    check_eq("empty_done_at", 32'(done_at), 1);
    check_eq("empty_loads", 32'(n_wl + n_il + n_sc), 0);

    // Reset during CALC of tile index 2
    clear_counts();
    cycle(1'b1, 4'd3, 1'b0, 5'd21, 4'd4, 1'b1);
    k = 0;
    while (n_sc < 3 && k < 500) begin
      cycle(1'b0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b1);
      k++;
    end
    check_eq("rst_reach_tile2", 32'(n_sc), 3);
    @(posedge CLK);
    #3;
    RSTN = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    check_eq("midrst_no_done", 32'(n_done), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("midrst_held_done", 32'(DONE), 0);
    RSTN = 1'b1;
    run_job(4'd2, 1'b1, 5'd6, 4'd8, 0);
    check_eq("post_rst_done_at", 32'(done_at), 27);
    check_eq("post_rst_sc", 32'(n_sc), 2);

    // Randomised jobs, back to back
    for (int j = 0; j < 25; j++) begin
      run_job(4'($urandom_range(0, 5)), 1'($urandom), 5'($urandom), 4'($urandom), 1);
      check_eq("rand_done_count", 32'(n_done), 1);
    end

    // A few idle cycles after the last job
    for (int j = 0; j < 3; j++) cycle(1'b0, 4'd3, 1'b1, 5'd1, 4'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
